mem_port_arbiter: RTL and testbench

//  Shares the single-port main-memory BRAM (64 KiB, 4x9-bit byte lanes incl. grubby bit) between two bus masters.
//  m0 is the Pipeline data/fetch port; m1 is a secondary master (DMA / debug loader).

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_arb_grant.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the main-memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response port of one bus master towards the memory arbiter.
// Request fields are held stable from valid until ready.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic                  valid;
  logic                  write;
  logic [MEM_MASK_W-1:0] wmask;
  logic [MEM_DATA_W-1:0] wdata;
  logic                  wgrubby;
  logic [31:0]           addr;
  logic                  ready;
  logic                  rvalid;
  logic [MEM_DATA_W-1:0] rdata;
  logic                  rgrubby;

  modport master (
    output valid, write, wmask, wdata, wgrubby, addr,
    input  ready, rvalid, rdata, rgrubby
  );

  modport slave (
    input  valid, write, wmask, wdata, wgrubby, addr,
    output ready, rvalid, rdata, rgrubby
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision for the two memory masters.
// Build option ARB_ROUND_ROBIN_EN: alternate on conflicts instead of
// m0 priority with the m1 starvation boost.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic v0,
  input  logic v1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ARB_ROUND_ROBIN_EN

  owner_e last_grant;

  // Conflicts go to whichever master did not win the previous accept.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (v1 && (!v0 || last_grant == OWN_M0)) gnt1 = 1'b1;
      else if (v0)                             gnt0 = 1'b1;
    end
  end

  // Remember the winner of every accept.
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= OWN_M0;
    else if (gnt1) last_grant <= OWN_M1;
    else if (gnt0) last_grant <= OWN_M0;
  end

`else

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             boost;

  // m0 wins conflicts unless the m1 boost is armed.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (v1 && (!v0 || boost)) gnt1 = 1'b1;
      else if (v0)              gnt0 = 1'b1;
    end
  end

  // Count m1 refusals; a refusal that finds the count saturated arms the
  // boost so m1 takes the next conflict. MAX_WAIT=0 never arms it.
  always_ff @(posedge clk) begin
    if (rst || !v1 || gnt1) begin
      wait_cnt <= '0;
      boost    <= 1'b0;
    end else begin
      if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
      boost <= (MAX_WAIT > 0) && (wait_cnt == CNT_MAX);
    end
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of the single-port main-memory BRAM.
// Same-cycle grant, request mux to memory, one-cycle read return routed
// back to the master that issued the read.
// Build option ARB_ROUND_ROBIN_EN selects round-robin conflict resolution.
//
// rd_own    | meaning
// OWN_NONE  | no read returning this cycle
// OWN_M0    | mem_rdata belongs to m0's read from the previous cycle
// OWN_M1    | mem_rdata belongs to m1's read from the previous cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     m0,
  mem_port_arbiter_if.slave     m1,
  output logic                  mem_write,
  output logic [MEM_MASK_W-1:0] mem_wmask,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  mem_wgrubby,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  input  logic                  mem_rgrubby
);

  logic   gnt0;
  logic   gnt1;
  owner_e rd_own;

  // Bits outside the 64 KiB word window are ignored by design.
  logic unused_addr;
  assign unused_addr = ^{m0.addr[31:ADDR_WIDTH+2], m0.addr[1:0],
                         m1.addr[31:ADDR_WIDTH+2], m1.addr[1:0]};

  mem_arb_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clk  (clk),
    .rst  (rst),
    .v0   (m0.valid),
    .v1   (m1.valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Grants already include valid, so ready doubles as accept.
  always_comb begin
    m0.ready = gnt0;
    m1.ready = gnt1;
  end

  // Drive the accepted request to memory; idle bus otherwise.
  always_comb begin
    mem_write   = 1'b0;
    mem_wmask   = '0;
    mem_wdata   = '0;
    mem_wgrubby = 1'b0;
    mem_addr    = '0;
    if (gnt0) begin
      mem_write   = m0.write;
      mem_wmask   = m0.wmask;
      mem_wdata   = m0.wdata;
      mem_wgrubby = m0.wgrubby;
      mem_addr    = m0.addr[ADDR_WIDTH+1:2];
    end else if (gnt1) begin
      mem_write   = m1.write;
      mem_wmask   = m1.wmask;
      mem_wdata   = m1.wdata;
      mem_wgrubby = m1.wgrubby;
      mem_addr    = m1.addr[ADDR_WIDTH+1:2];
    end
  end

  // Track which master owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst)                    rd_own <= OWN_NONE;
    else if (gnt0 && !m0.write) rd_own <= OWN_M0;
    else if (gnt1 && !m1.write) rd_own <= OWN_M1;
    else                        rd_own <= OWN_NONE;
  end

  // Route returning data to its owner; reset discards an in-flight read.
  always_comb begin
    m0.rvalid  = !rst && (rd_own == OWN_M0);
    m1.rvalid  = !rst && (rd_own == OWN_M1);
    m0.rdata   = m0.rvalid ? mem_rdata   : '0;
    m0.rgrubby = m0.rvalid ? mem_rgrubby : 1'b0;
    m1.rdata   = m1.rvalid ? mem_rdata   : '0;
    m1.rgrubby = m1.rvalid ? mem_rgrubby : 1'b0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural BRAM model.
// Expectations follow the build option ARB_ROUND_ROBIN_EN when defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_wgrubby;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rgrubby;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if m0_if ();
  mem_port_arbiter_if m1_if ();

  mem_port_arbiter #(.ADDR_WIDTH(14), .MAX_WAIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .mem_write   (mem_write),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_wgrubby (mem_wgrubby),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rgrubby (mem_rgrubby)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [13:0] w);
    return {16'hBEEF ^ {2'b00, w}, 2'b00, w};
  endfunction

  function automatic logic patg(input logic [13:0] w);
    return w[0] ^ w[3];
  endfunction

  // BRAM model: registered read, byte-lane writes, grubby tag per word.
  logic [31:0] mem_arr [0:16383];
  logic        mem_g   [0:16383];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem_arr[i] = pat(14'(i));
      mem_g[i]   = patg(14'(i));
    end
  end

  always @(posedge clk) begin
    mem_rdata   <= mem_arr[mem_addr];
    mem_rgrubby <= mem_g[mem_addr];
    if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem_arr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (|mem_wmask) mem_g[mem_addr] <= mem_wgrubby;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int m, input logic v, input logic w, input logic [3:0] mask,
                     input logic [31:0] data, input logic g, input logic [31:0] a);
    if (m == 0) begin
      m0_if.valid = v; m0_if.write = w; m0_if.wmask = mask;
      m0_if.wdata = data; m0_if.wgrubby = g; m0_if.addr = a;
    end else begin
      m1_if.valid = v; m1_if.write = w; m1_if.wmask = mask;
      m1_if.wdata = data; m1_if.wgrubby = g; m1_if.addr = a;
    end
  endtask

  task automatic idle(input int m);
    drv(m, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] w;
    logic [13:0] wa;
    logic        g1;
    logic        prev_g1;
    int          prev_m;
    logic [31:0] prev_a;

    rst = 1'b1;
    idle(0);
    idle(1);
    drv(0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h10);
    @(negedge clk);
    chk("rst_m0_ready", m0_if.ready, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_m0_rvalid", m0_if.rvalid, 0);
    cyc();
    cyc();
    rst = 1'b0;

    // single m0 read
    drv(0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0000_FE00);
    @(negedge clk);
    chk("t1_m0_ready", m0_if.ready, 1);
    chk("t1_m1_ready", m1_if.ready, 0);
    chk("t1_mem_addr", mem_addr, 14'h3F80);
    chk("t1_mem_write", mem_write, 0);
    cyc();
    idle(0);
    @(negedge clk);
    chk("t1_m0_rvalid", m0_if.rvalid, 1);
    chk("t1_m0_rdata", m0_if.rdata, pat(14'h3F80));
    chk("t1_m0_rgrubby", m0_if.rgrubby, patg(14'h3F80));
    chk("t1_m1_rvalid", m1_if.rvalid, 0);
    cyc();
    @(negedge clk);
    chk("t1_idle_rvalid", m0_if.rvalid, 0);
    chk("t1_idle_rdata", m0_if.rdata, 0);
    chk("t1_idle_addr", mem_addr, 0);

    // high and low address bits ignored
    cyc();
    drv(1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'hFFFF_FE03);
    @(negedge clk);
    chk("wrap_m1_ready", m1_if.ready, 1);
    chk("wrap_mem_addr", mem_addr, 14'h3F80);
    cyc();
    idle(1);
    @(negedge clk);
    chk("wrap_m1_rvalid", m1_if.rvalid, 1);
    chk("wrap_m1_rdata", m1_if.rdata, pat(14'h3F80));

    // partial write by m1, read back by m0
    cyc();
    drv(1, 1'b1, 1'b1, 4'b0011, 32'h1234_5678, 1'b1, 32'h100);
    @(negedge clk);
    chk("t3_m1_ready", m1_if.ready, 1);
    chk("t3_mem_write", mem_write, 1);
    chk("t3_mem_wmask", mem_wmask, 4'b0011);
    chk("t3_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t3_mem_addr", mem_addr, 14'h40);
    cyc();
    idle(1);
    drv(0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h100);
    @(negedge clk);
    chk("t3_write_no_rvalid", m1_if.rvalid, 0);
    chk("t3_m0_ready", m0_if.ready, 1);
    chk("t3_rd_mem_write", mem_write, 0);
    cyc();
    idle(0);
    @(negedge clk);
    w = pat(14'h40);
    chk("t3_m0_rvalid", m0_if.rvalid, 1);
    chk("t3_m0_rdata", m0_if.rdata, {w[31:16], 16'h5678});
    chk("t3_m0_rgrubby", m0_if.rgrubby, 1);

    // alternating single-master reads, back to back
    prev_m = 0;
    prev_a = 32'h0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      idle(0);
      idle(1);
      drv(i % 2, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h400 + 32'(i) * 32'h44);
      @(negedge clk);
      chk("t4_ready", (i % 2 == 0) ? m0_if.ready : m1_if.ready, 1);
      chk("t4_other_ready", (i % 2 == 0) ? m1_if.ready : m0_if.ready, 0);
      if (i > 0) begin
        wa = prev_a[15:2];
        chk("t4_m0_rvalid", m0_if.rvalid, (prev_m == 0));
        chk("t4_m1_rvalid", m1_if.rvalid, (prev_m == 1));
        chk("t4_rdata", (prev_m == 0) ? m0_if.rdata : m1_if.rdata, pat(wa));
      end
      prev_m = i % 2;
      prev_a = 32'h400 + 32'(i) * 32'h44;
    end
    cyc();
    idle(0);
    idle(1);
    @(negedge clk);
    wa = prev_a[15:2];
    chk("t4_last_m1_rvalid", m1_if.rvalid, 1);
    chk("t4_last_m0_rvalid", m0_if.rvalid, 0);
    chk("t4_last_rdata", m1_if.rdata, pat(wa));

    // reset right after an m1 read accept
    cyc();
    drv(1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h800);
    @(negedge clk);
    chk("t5_m1_ready", m1_if.ready, 1);
    cyc();
    idle(1);
    rst = 1'b1;
    drv(0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h20);
    @(negedge clk);
    chk("t5_m1_rvalid", m1_if.rvalid, 0);
    chk("t5_m1_rdata", m1_if.rdata, 0);
    chk("t5_m0_ready", m0_if.ready, 0);
    chk("t5_mem_write", mem_write, 0);
    chk("t5_mem_addr", mem_addr, 0);
    cyc();
    idle(0);
    @(negedge clk);
    chk("t5_hold_m1_rvalid", m1_if.rvalid, 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_m1_rvalid", m1_if.rvalid, 0);
    chk("t5_post_m0_rvalid", m0_if.rvalid, 0);

    // continuous conflict from reset
    prev_g1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      drv(0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h200);
      drv(1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h300);
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      g1 = (c % 2 == 1);
`else
      g1 = (c % 10 == 0);
`endif
      chk($sformatf("conf_m1_ready_c%0d", c), m1_if.ready, g1);
      chk($sformatf("conf_m0_ready_c%0d", c), m0_if.ready, !g1);
      if (c > 1) begin
        chk($sformatf("conf_m1_rvalid_c%0d", c), m1_if.rvalid, prev_g1);
        chk($sformatf("conf_m0_rvalid_c%0d", c), m0_if.rvalid, !prev_g1);
        chk($sformatf("conf_rdata_c%0d", c), prev_g1 ? m1_if.rdata : m0_if.rdata,
            prev_g1 ? pat(14'hC0) : pat(14'h80));
      end
      prev_g1 = g1;
    end
    cyc();
    idle(0);
    idle(1);
    @(negedge clk);
    chk("end_m0_ready", m0_if.ready, 0);
    chk("end_m1_ready", m1_if.ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
